cla_serial_adder32: RTL and testbench
=====================================

CLA_SERIAL_ADDER32 -- requirements
Module: cla_serial_adder32

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, setting the operand width to 8*NBYTES bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-005 The block SHALL have port op_a, input, 8*NBYTES bits: unsigned operand A, sampled when start is accepted.
REQ-006 The block SHALL have port op_b, input, 8*NBYTES bits: unsigned operand B, sampled when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, 8*NBYTES+1 bits: the sum op_a+op_b, with the MSB as the final carry.

Function
REQ-010 The state machine SHALL have three states:
- IDLE to ADD: on start=1.
- ADD to DONE: after the last byte.
- DONE to IDLE: unconditionally after one cycle.
REQ-011 In IDLE, start=1 at edge E0 SHALL latch op_a and op_b into internal registers, clear the carry register and the byte index, clear the result register, and enter ADD.
REQ-012 The start input SHALL be ignored in ADD and DONE; operands latched at E0 SHALL remain unchanged until the operation ends.
REQ-013 In ADD, each cycle SHALL process one byte, LSB first. Byte i (i=0..NBYTES-1) SHALL be written to result[8i+7:8i] at edge E(i+1).
REQ-014 Each byte sum SHALL be computed with two cla_8bit instances:
- s1 = a_byte + b_byte (9 bits).
- s2 = s1[7:0] + {7'b0, carry} (9 bits).
- The stored byte SHALL be s2[7:0].
- The next carry SHALL be s1[8] | s2[8]; at most one of the two is ever 1.
REQ-015 At edge E(NBYTES), the final carry SHALL be written to result[8*NBYTES] and the state SHALL become DONE.
REQ-016 Signal busy SHALL be 1 exactly in ADD, i.e. from edge E0 to edge E(NBYTES).
REQ-017 Signal done SHALL be 1 exactly in DONE: a single cycle from edge E(NBYTES) to edge E(NBYTES+1). Start-to-done latency is NBYTES edges.
REQ-018 Signal result SHALL hold its completed value from done onward, through IDLE, until the next accepted start clears it.
REQ-019 A start held high through DONE SHALL be accepted at the first edge in IDLE. The minimum period between back-to-back operations is NBYTES+2 cycles.
REQ-020 The byte index SHALL be ceil(log2(NBYTES))+1 bits wide and SHALL never wrap during ADD.
REQ-021 All arithmetic SHALL be unsigned. Sums of all-ones operands SHALL propagate the carry through every byte with no truncation.

Reset
REQ-022 With rst_n=0 at a rising edge, the next state SHALL be IDLE, and busy=0, done=0, result=0, carry=0, and the byte index=0.
REQ-023 Reset SHALL take priority over start and over any state, including mid-ADD. An interrupted operation SHALL produce no done pulse.
REQ-024 Outputs SHALL be registered; no output SHALL depend combinationally on start, op_a, or op_b.

Verification
REQ-025 Zero operands: NBYTES=4, op_a=0, op_b=0, start pulse. The bench SHALL check that done fires 4 edges after start and result=33'h0_0000_0000.
REQ-026 Full carry chain: op_a=32'hFFFF_FFFF, op_b=32'h0000_0001. The bench SHALL check result=33'h1_0000_0000, busy high for exactly 4 cycles, and done high for exactly 1 cycle.
REQ-027 Typical sum: op_a=32'h1234_5678, op_b=32'h1111_1111. The bench SHALL check result=33'h0_2345_6789.
REQ-028 Start while busy: op_a=1, op_b=2 is started, then start=1 with op_a=op_b=32'hFFFF_FFFF two cycles later. The bench SHALL check that result=3, only one done pulse occurs, and the second request is ignored.
REQ-029 Reset mid-operation: rst_n=0 in the second ADD cycle. The bench SHALL check busy=0, done=0, and result=0 at the next edge, and that a subsequent op_a=5, op_b=7 gives result=12.
REQ-030 Exhaustive sweep: op_a and op_b each 0..7, compared against the reference sum a+b.
- The bench SHALL flag any result mismatch.
- The bench SHALL flag any done pulse that does not occur exactly NBYTES edges after its start.

Source files
------------

// File: rtl/cla_serial_adder32.sv
// Byte-serial unsigned adder: one byte per cycle, LSB first, built from two 8-bit CLA slices.
// cla_8bit computes each carry as a flattened generate/propagate lookahead term.

module cla_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   logic       acc;
   logic       prop;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      acc  = 1'b0;
      prop = 1'b0;
      c[0] = cin;
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
      for (int unsigned i = 0; i < 8; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int unsigned j = 0; j < i; j++) begin
            acc  = acc | (prop & g[i-1-j]);
            prop = prop & p[i-1-j];
         end
         c[i+1] = acc | (prop & cin);
      end
      sum  = p ^ c[7:0];
      cout = c[8];
   end

endmodule

module cla_serial_adder32 #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES:0]   result
);

   localparam int unsigned W    = 8 * NBYTES;
   localparam int unsigned IDXW = $clog2(NBYTES) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [W:0]      result_q, result_d;

   logic [7:0]      a_byte, b_byte;
   logic [7:0]      s1_sum, s2_sum;
   logic            s1_cout, s2_cout;
   logic            carry_next;
   logic            last_byte;

   always_comb begin
      a_byte    = '0;
      b_byte    = '0;
      last_byte = (idx_q == IDXW'(NBYTES - 1));
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_byte = a_q[8*i +: 8];
            b_byte = b_q[8*i +: 8];
         end
      end
   end

   cla_8bit u_s1 (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (1'b0),
      .sum  (s1_sum),
      .cout (s1_cout)
   );

   // Incoming carry is folded in by a second slice; s1 and s2 never both carry out.
   cla_8bit u_s2 (
      .a    (s1_sum),
      .b    ({7'b0, carry_q}),
      .cin  (1'b0),
      .sum  (s2_sum),
      .cout (s2_cout)
   );

   assign carry_next = s1_cout | s2_cout;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = op_a;
               b_d      = op_b;
               carry_d  = 1'b0;
               idx_d    = '0;
               result_d = '0;
               state_d  = ADD;
            end
         end
         ADD: begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  result_d[8*i +: 8] = s2_sum;
               end
            end
            carry_d = carry_next;
            idx_d   = idx_q + IDXW'(1);
            if (last_byte) begin
               result_d[W] = carry_next;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == ADD);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_cla_serial_adder32.sv
// Directed bench for cla_serial_adder32 (NBYTES=4): hand-computed sums, latency, busy/done shape.

module tb_cla_serial_adder32;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [32:0] result;

   int nvec;
   int nerr;

   cla_serial_adder32 #(.NBYTES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launches one operation and observes every edge until one edge past done.
   // lat is the number of edges after the accepting edge at which done was seen (-1 if never).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [32:0] res, output int lat,
                        output int busy_cnt, output int done_cnt);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      lat      = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (lat < 0) lat = k;
         end else if (lat >= 0) begin
            break;
         end
      end
      res = result;
   endtask

   initial begin
      logic [32:0] res;
      logic [32:0] res_at_done;
      int          lat;
      int          bcnt;
      int          dcnt;

      nvec  = 0;
      nerr  = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;

      // Reset, with start asserted to confirm reset wins
      @(negedge clk);
      start = 1'b1;
      op_a  = 32'hDEAD_BEEF;
      op_b  = 32'h1234_5678;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_busy", 33'(busy), 33'd0);
      check("reset_done", 33'(done), 33'd0);
      check("reset_result", result, 33'h0);
      start = 1'b0;
      rst_n = 1'b1;

      // Zero operands
      do_op(32'h0, 32'h0, res, lat, bcnt, dcnt);
      check("zero_latency", 33'(lat), 33'd4);
      check("zero_result", res, 33'h0_0000_0000);

      // Full carry chain
      do_op(32'hFFFF_FFFF, 32'h0000_0001, res, lat, bcnt, dcnt);
      check("carry_result", res, 33'h1_0000_0000);
      check("carry_busy_cycles", 33'(bcnt), 33'd4);
      check("carry_done_cycles", 33'(dcnt), 33'd1);
      check("carry_latency", 33'(lat), 33'd4);

      // All-ones on both operands
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt, dcnt);
      check("ones_result", res, 33'h1_FFFF_FFFE);

      // Typical sum
      do_op(32'h1234_5678, 32'h1111_1111, res, lat, bcnt, dcnt);
      check("typical_result", res, 33'h0_2345_6789);

      // Result holds in IDLE
      @(posedge clk);
      #1;
      check("hold_result", result, 33'h0_2345_6789);

      // Start while busy: second request two cycles later must be ignored
      @(negedge clk);
      op_a  = 32'd1;
      op_b  = 32'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b1;
      op_a  = 32'hFFFF_FFFF;
      op_b  = 32'hFFFF_FFFF;
      dcnt  = 0;
      res_at_done = '1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
         dcnt++;
         res_at_done = result;
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dcnt++;
            res_at_done = result;
         end
      end
      check("busy_start_done_count", 33'(dcnt), 33'd1);
      check("busy_start_result", res_at_done, 33'd3);
      check("busy_start_final_result", result, 33'd3);
      check("busy_start_idle", 33'(busy), 33'd0);

      // Reset in the second ADD cycle
      @(negedge clk);
      op_a  = 32'd9;
      op_b  = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", 33'(busy), 33'd0);
      check("midrst_done", 33'(done), 33'd0);
      check("midrst_result", result, 33'h0);
      rst_n = 1'b1;
      dcnt  = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      check("midrst_no_done", 33'(dcnt), 33'd0);
      do_op(32'd5, 32'd7, res, lat, bcnt, dcnt);
      check("post_rst_result", res, 33'd12);
      check("post_rst_latency", 33'(lat), 33'd4);

      // Sweep 0..7 x 0..7
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            do_op(32'(a), 32'(b), res, lat, bcnt, dcnt);
            check($sformatf("sweep_result_%0d_%0d", a, b), res, 33'(a + b));
            check($sformatf("sweep_latency_%0d_%0d", a, b), 33'(lat), 33'd4);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
